ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single CPU-side port of the 4x2048x32 on-chip RAM between two requesters: the PicoRV32 native memory interface (cpu) and a DMA/fill engine (dma).
- Sequences each access: grant, one-cycle select/write strobe, wait for the block-RAM read latency, registered rdata/ready return.
- Sits between the CPU/DMA bus logic and the RAM wrapper's sel/wen/address/wdata/rdata port, in the clk_cpu domain.

Parameters:
- ADDR_W, 16, width of RAM address passed through unchanged to the RAM port.
- LAT, 1, RAM read latency in cycles, legal range 1..3; extra wait states = LAT-1.

Ports:
- clk_cpu  in  1  system/CPU clock; every register is rising-edge clocked.
- rst  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  CPU request; held high until cpu_ready.
- cpu_addr  in  ADDR_W  CPU RAM address.
- cpu_wstrb  in  4  byte write enables; 0 means read.
- cpu_wdata  in  32  CPU write data.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- dma_valid, dma_addr, dma_wstrb, dma_wdata  in  1/ADDR_W/4/32  DMA request, same rules as cpu_*.
- dma_ready  out  1  one-cycle completion pulse to DMA.
- dma_rdata  out  32  read data, valid while dma_ready=1.
- ram_sel  out  1  RAM port select, high exactly one cycle per access.
- ram_wen  out  4  byte write enables, equal to latched wstrb while ram_sel=1, else 0.
- ram_address  out  ADDR_W  latched address of the current access.
- ram_wdata  out  32  latched write data of the current access.
- ram_rdata  in  32  RAM read data, valid LAT cycles after the ram_sel edge.

Behaviour:
- Reset state:
  - ram_sel=0, ram_wen=0, ram_address=0, ram_wdata=0.
  - cpu_ready=0, dma_ready=0, cpu_rdata=0, dma_rdata=0.
  - FSM in IDLE; last_grant=DMA, so the CPU wins the first tie.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE -> ISSUE -> WAIT (LAT-1 cycles, skipped when LAT=1) -> RESP -> DONE -> IDLE.
- IDLE:
  - Grant rule: if exactly one valid is high, grant it; if both are high, grant the requester that is not last_grant.
  - On grant, latch addr/wdata/wstrb and the grant id, update last_grant, go to ISSUE.
  - With no valid high, stay in IDLE.
- ISSUE: ram_sel=1 and ram_wen=wstrb for this single cycle; a wait counter is loaded with LAT-1.
- WAIT: count down; go to RESP when the counter reaches 0.
- RESP: capture ram_rdata into the granted requester's rdata register, then go to DONE. Writes follow the same timing; rdata is undefined but still registered.
- DONE:
  - Granted requester's ready=1 for exactly this cycle; then back to IDLE.
  - No arbitration in DONE, so the still-high valid of the just-served requester is never re-issued.
- Latency, LAT=1: valid first sampled in IDLE at edge E -> ram_sel high in cycle E+1 -> ready high in cycle E+3.
- Latency, general case: ready high in cycle E+2+LAT; back-to-back throughput is one access per 3+LAT cycles.
- Ungranted requester: its ready stays 0 and its rdata holds its previous value.
- Valid dropped mid-transaction (protocol violation): the access still completes and the ready pulse is still issued.
- Reset asserted mid-transaction: immediate return to the reset state; the access is abandoned with no ready pulse, and the requester re-presents it.
- Simultaneous new requests while busy: ignored until IDLE; requesters hold their valid.
- Address, wdata and wstrb are passed at full width; bank decode and range are the RAM wrapper's concern.

Optional Feature:
- Macro: RAM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority; cpu wins every tie and last_grant is not used.
- Undefined (default): round-robin as above.

Test Plan:
- CPU read only, RAM preloaded with addr 0x0010 = 0xDEADBEEF:
  - ram_sel pulses once with ram_address=0x0010 and ram_wen=0.
  - cpu_ready high in cycle E+3 with cpu_rdata=0xDEADBEEF; dma_ready stays 0.
- DMA write, addr 0x2004, wstrb=4'b0011, wdata=0x12345678:
  - One-cycle ram_sel with ram_wen=4'b0011.
  - A later CPU read of 0x2004 returns 0x????5678, preserving the upper bytes.
- Both valid held continuously for 4 accesses each, from reset: grants alternate CPU, DMA, CPU, DMA, ...
- Same stimulus with RAM_ARB_CPU_PRIORITY_EN defined: all 4 CPU accesses complete before the first dma_ready.
- LAT=3 build, CPU read: ram_sel in cycle E+1, cpu_ready in cycle E+5 with the correct data.
- rst pulsed in the cycle after ram_sel of a CPU read:
  - All outputs return to 0 asynchronously and no cpu_ready occurs.
  - After release, the held cpu_valid is re-granted and completes normally.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Request/response ports of the CPU and DMA requesters plus the shared RAM port.
// slave: the arbiter side; master: the requesters and the RAM wrapper.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [3:0]        cpu_wstrb;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;

    logic              dma_valid;
    logic [ADDR_W-1:0] dma_addr;
    logic [3:0]        dma_wstrb;
    logic [31:0]       dma_wdata;
    logic              dma_ready;
    logic [31:0]       dma_rdata;

    logic              ram_sel;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
        output cpu_ready, cpu_rdata,
        input  dma_valid, dma_addr, dma_wstrb, dma_wdata,
        output dma_ready, dma_rdata,
        output ram_sel, ram_wen, ram_address, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
        input  cpu_ready, cpu_rdata,
        output dma_valid, dma_addr, dma_wstrb, dma_wdata,
        input  dma_ready, dma_rdata,
        input  ram_sel, ram_wen, ram_address, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between cpu and dma; round-robin ties, or cpu-first with RAM_ARB_CPU_PRIORITY_EN.
// Latency: ram_sel one cycle after the grant edge, ready pulse LAT+2 cycles after it.
// Backpressure: requesters hold valid until their ready pulse; requests during an access wait for IDLE.
module ram_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LAT    = 1
) (
    input  logic              clk_cpu,
    input  logic              rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DONE} state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(LAT - 1);

    state_t            state;
    logic              gnt_dma;
    logic [1:0]        wait_cnt;
    logic              any_valid;
    logic              pick_dma;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;

    assign any_valid = bus.cpu_valid | bus.dma_valid;

`ifdef RAM_ARB_CPU_PRIORITY_EN
    assign pick_dma = ~bus.cpu_valid;
`else
    logic last_dma;
    // On a tie, the side that was not served last wins.
    assign pick_dma = bus.dma_valid & (~bus.cpu_valid | ~last_dma);
`endif

    assign req_addr  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
    assign req_wdata = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
    assign req_wstrb = pick_dma ? bus.dma_wstrb : bus.cpu_wstrb;

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            gnt_dma         <= 1'b0;
            wait_cnt        <= 2'd0;
            bus.ram_sel     <= 1'b0;
            bus.ram_wen     <= 4'h0;
            bus.ram_address <= '0;
            bus.ram_wdata   <= 32'h0;
            bus.cpu_ready   <= 1'b0;
            bus.dma_ready   <= 1'b0;
            bus.cpu_rdata   <= 32'h0;
            bus.dma_rdata   <= 32'h0;
`ifndef RAM_ARB_CPU_PRIORITY_EN
            last_dma        <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt_dma         <= pick_dma;
                        bus.ram_address <= req_addr;
                        bus.ram_wdata   <= req_wdata;
                        bus.ram_wen     <= req_wstrb;
                        bus.ram_sel     <= 1'b1;
`ifndef RAM_ARB_CPU_PRIORITY_EN
                        last_dma        <= pick_dma;
`endif
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.ram_sel <= 1'b0;
                    bus.ram_wen <= 4'h0;
                    wait_cnt    <= WAIT_LOAD;
                    state       <= (LAT == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 2'd1;
                    if (wait_cnt <= 2'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Write accesses capture too; their rdata is simply not meaningful.
                    if (gnt_dma) begin
                        bus.dma_rdata <= bus.ram_rdata;
                        bus.dma_ready <= 1'b1;
                    end else begin
                        bus.cpu_rdata <= bus.ram_rdata;
                        bus.cpu_ready <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    bus.cpu_ready <= 1'b0;
                    bus.dma_ready <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
